// File: rtl/onchip_mem_test_master_if.sv
// onchip_mem_test_master_if: Avalon-MM request/response bus between the test master and a single-port on-chip RAM.
interface onchip_mem_test_master_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_clken;
    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );
    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );
endinterface

// File: rtl/onchip_mem_test_master.sv
// onchip_mem_test_master: writes a pattern over a RAM window, reads it back and counts mismatches.
// Define ONCHIP_MEM_TEST_LFSR_EN for a Galois LFSR pattern instead of seed ^ address.
module onchip_mem_test_master #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [15:0]          num_words,
    input  logic [DATA_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    onchip_mem_test_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t              state;
    logic [15:0]         n_r, idx;
    logic [ADDR_W-1:0]   base_r, exp_a, next_addr;
    logic [DATA_W-1:0]   seed_r, exp_d, pat_start, pat_next, pat_reload;
    logic                cmp_v, last;
    assign next_addr = bus.m_address + 1'b1;
    assign last = idx == n_r - 16'd1;
    assign bus.m_byteenable = '1;
    assign bus.m_clken = !reset;
`ifdef ONCHIP_MEM_TEST_LFSR_EN
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(32'h80200003);
    assign pat_start  = seed == '0 ? DATA_W'(1) : seed;
    assign pat_reload = seed_r == '0 ? DATA_W'(1) : seed_r;
    assign pat_next   = {1'b0, bus.m_writedata[DATA_W-1:1]} ^ (bus.m_writedata[0] ? TAPS : '0);
`else
    assign pat_start  = seed ^ DATA_W'(base_addr);
    assign pat_reload = seed_r ^ DATA_W'(base_r);
    assign pat_next   = seed_r ^ DATA_W'(next_addr);
`endif
    // m_writedata doubles as the expected word during READ; it is delayed one cycle to meet read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            first_err_addr <= '0;
            cmp_v <= 1'b0;
            bus.m_chipselect <= 1'b0;
            bus.m_write <= 1'b0;
            bus.m_address <= '0;
            bus.m_writedata <= '0;
        end else begin
            done <= 1'b0;
            cmp_v <= state == READ;
            exp_d <= bus.m_writedata;
            exp_a <= bus.m_address;
            if (cmp_v && bus.m_readdata != exp_d) begin
                err_count <= err_count + {15'd0, err_count != 16'hFFFF};
                if (err_count == '0) first_err_addr <= exp_a;
            end
            case (state)
                IDLE: if (start) begin
                    state <= num_words == '0 ? DONE : WRITE;
                    busy <= 1'b1;
                    pass <= 1'b0;
                    err_count <= '0;
                    first_err_addr <= '0;
                    idx <= '0;
                    n_r <= num_words;
                    base_r <= base_addr;
                    seed_r <= seed;
                    bus.m_chipselect <= num_words != '0;
                    bus.m_write <= num_words != '0;
                    bus.m_address <= base_addr;
                    bus.m_writedata <= pat_start;
                end
                WRITE, READ: begin
                    idx <= last ? '0 : idx + 16'd1;
                    bus.m_address <= last ? base_r : next_addr;
                    bus.m_writedata <= last ? pat_reload : pat_next;
                    if (last) begin
                        state <= state == WRITE ? READ : DRAIN;
                        bus.m_write <= 1'b0;
                        bus.m_chipselect <= state == WRITE;
                    end
                end
                DRAIN: state <= DONE;
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= err_count == '0;
                end
            endcase
        end
    end
endmodule

// File: doc/onchip_mem_test_master.md
ONCHIP_MEM_TEST_MASTER -- requirements
Module: onchip_mem_test_master

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width of the target memory.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width DATA_W/8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse, begins a test run when idle.
REQ-006 base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-007 num_words  input  16  words to test, sampled on accepted start.
REQ-008 seed  input  DATA_W  pattern seed, sampled on accepted start.
REQ-009 busy  output  1  high from cycle after accepted start until done asserts.
REQ-010 done  output  1  one-cycle pulse at end of run.
REQ-011 pass  output  1  valid from done until next accepted start; 1 = zero mismatches.
REQ-012 err_count  output  16  mismatch count, saturating at 16'hFFFF.
REQ-013 first_err_addr  output  ADDR_W  address of first mismatch; 0 if none.
REQ-014 m_address, m_byteenable, m_chipselect, m_write, m_writedata  outputs  ADDR_W/DATA_W/8/1/1/DATA_W  Avalon-MM master request to single-port on-chip RAM.
REQ-015 m_readdata  input  DATA_W  RAM read data, fixed read latency 1, no waitrequest.
REQ-016 m_clken  output  1  RAM clock enable; held 1 except in reset.

Function
REQ-017 States IDLE, WRITE, READ, DRAIN, DONE; start accepted only in IDLE, ignored otherwise.
REQ-018 IDLE + start, num_words>0 -> WRITE; num_words==0 -> DONE (pass=1, err_count=0).
REQ-019 WRITE: one write per cycle, m_chipselect=m_write=1, m_byteenable all ones, address base_addr+i for i=0..num_words-1.
REQ-020 Address arithmetic modulo 2^ADDR_W; base_addr+i wraps past all-ones to 0.
REQ-021 After last write -> READ next cycle; m_write=0, m_chipselect=1, one read per cycle over the same address sequence.
REQ-022 Expected data and address pipelined one cycle; m_readdata compared in cycle after each read issue.
REQ-023 After last read issue -> DRAIN for one cycle (final compare, m_chipselect=0) -> DONE.
REQ-024 DONE: done=1 and busy=0 for one cycle, then IDLE; pass = (err_count==0).
REQ-025 Mismatch: err_count increments (saturating); first mismatch only loads first_err_addr.
REQ-026 err_count, first_err_addr, pass cleared on accepted start; held stable in IDLE.
REQ-027 Run length exactly 2*num_words+2 cycles from start to done for num_words>0.
REQ-028 Default pattern word i: seed XOR zero-extended (base_addr+i).

Reset
REQ-029 reset, any state, next edge: state IDLE; busy, done, pass, m_chipselect, m_write=0; err_count, first_err_addr, m_address, m_writedata=0; m_byteenable all ones; m_clken=0 during reset, 1 afterward.
REQ-030 reset mid-run abandons run without done pulse; start in first post-reset cycle is accepted.

Configuration
REQ-031 Macro ONCHIP_MEM_TEST_LFSR_EN defined: pattern is 32-bit Galois LFSR, taps 32'h80200003, loaded with seed (seed 0 replaced by 1), advanced once per word, reloaded at READ entry.
REQ-032 Macro undefined: REQ-028 pattern, no LFSR logic synthesised; interface and timing identical.

Verification
REQ-033 base=0, num=4, seed=32'hA5A50000, ideal RAM model -> writes A5A50000..A5A50003, done at cycle 10, pass=1, err_count=0.
REQ-034 Same run, model corrupts word at address 2 (bit 0 flipped) -> pass=0, err_count=1, first_err_addr=2.
REQ-035 base=15'h7FFE, num=4 -> addresses 7FFE, 7FFF, 0000, 0001 in both phases, pass=1.
REQ-036 num_words=0 -> done one cycle after DONE entry, no m_chipselect activity, pass=1.
REQ-037 reset asserted during READ at i=2 -> strobes low next edge, no done, new start runs clean to pass=1.
REQ-038 start pulsed while busy -> ignored, run completes unchanged; with ONCHIP_MEM_TEST_LFSR_EN, seed=0 -> first written word 32'h00000001.
